md_arbiter: RTL and testbench
=============================

Name: md_arbiter

Overview:
- Shares the single-port data memory between the processor control path (MAR/MBR side) and a DMA/loader port used to preload and dump data memory.
- Each requester uses a req/ack handshake. The block serialises their accesses with round-robin arbitration and a fixed-latency read pipeline.
- Sits between processor_fsm/mar/mbr and the data memory. It drives the memory address, write data, wren and clock-enable.

Parameters:
ADDR_W, 12, data-memory address width
DATA_W, 16, data word width
RD_LAT, 2, cycles from issue cycle to valid mem_q (must be >=1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cpu_req  in  1  processor access request, held until cpu_ack
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  processor address (from MAR)
cpu_wdata  in  DATA_W  processor write data (from MBR)
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  read data, valid from cpu_ack onward
dma_req  in  1  DMA request, held until dma_ack
dma_we  in  1  1=write, 0=read
dma_addr  in  ADDR_W  DMA address
dma_wdata  in  DATA_W  DMA write data
dma_ack  out  1  one-cycle completion pulse
dma_rdata  out  DATA_W  read data, valid from dma_ack onward
mem_addr  out  ADDR_W  memory address
mem_data  out  DATA_W  memory write data
mem_wren  out  1  memory write enable
mem_en  out  1  memory clock enable (access strobe)
mem_q  in  DATA_W  memory read data
busy  out  1  1 whenever state != IDLE
owner  out  1  0=cpu, 1=dma; valid while busy

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, last_owner=1 (dma), so the cpu wins the first tie.
  - All outputs are 0: acks, rdata registers, mem_*, busy, owner.
  - An in-flight transaction is aborted with no ack and no further mem_en/mem_wren.
- All outputs are registered except busy and owner, which decode state.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant it.
  - Both req: grant the requester that is not last_owner.
  - On grant: latch we/addr/wdata of the winner, set owner, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_en=1, mem_addr=latched addr, mem_wren=latched we, mem_data=latched wdata.
  - Write: go to DONE.
  - Read: go to WAIT, wait counter=0.
- WAIT (exactly RD_LAT cycles): mem_en=0, mem_wren=0. In the last WAIT cycle, capture mem_q into the owner's rdata register, then go to DONE.
- DONE (1 cycle):
  - Owner's ack=1; last_owner=owner; go to IDLE.
  - The non-owner's ack and rdata are untouched.
- Latency, counted from the cycle the req is first sampled in IDLE (cycle 0):
  - Write ack in cycle 2.
  - Read ack in cycle 2+RD_LAT (cycle 4 at default).
  - Back-to-back: a req still high in the IDLE cycle after DONE is a new request. The minimum spacing between issues is 3 cycles for writes and 3+RD_LAT for reads.
- Requester rules:
  - Drop req on the edge that ends its ack cycle.
  - Inputs are latched at grant, so later changes do not affect the current transaction.
  - If req drops before ack, the transaction still completes and ack still pulses.
- rdata registers hold their value until the next completed read by the same requester. Writes never modify rdata.
- Fairness: with both requesters held high continuously, grants strictly alternate. Neither requester waits more than one foreign transaction.
- Only one memory access is in flight at a time: mem_en=1 only in ISSUE, at most one cycle per transaction.
- A req arriving while busy is ignored until IDLE. It is never lost provided it is held.
- Address is used as-is; wrap-around is the memory's concern. No other range check.

Test Plan:
- Reset check: reset=0 mid-read (in WAIT) -> cpu_ack never pulses, mem_en=0, busy=0, cpu_rdata=0. Release -> IDLE.
- CPU write then read: cpu write addr 0x012 data 0x7FFF -> mem_en=mem_wren=1, mem_addr=0x012 in cycle 1, cpu_ack in cycle 2. CPU read 0x012 with model memory returning 0x7FFF after RD_LAT=2 -> cpu_ack in cycle 4, cpu_rdata=0x7FFF.
- Simultaneous first requests: both req in the same cycle after reset -> cpu served first (owner=0), then dma. dma_ack never overlaps cpu_ack.
- Continuous contention: both reqs held for 6 transactions -> owners alternate 0,1,0,1,0,1. Each ISSUE has exactly one mem_en pulse.
- Input change after grant: cpu read 0x0A0 granted, then cpu_addr changed to 0xFFF during WAIT -> mem_addr was 0x0A0, and dma_rdata is unchanged.
- RD_LAT=1 build: dma read of 0x800 returning 0x8001 -> dma_ack in cycle 3, dma_rdata=0x8001 (negative value preserved bit-exact).

Source files
------------

// File: rtl/md_arbiter.sv
// rtl/md_arbiter.sv - round-robin arbiter sharing the data memory between the cpu and dma ports
module md_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    output logic              mem_en,
    input  logic [DATA_W-1:0] mem_q,
    output logic              busy,
    output logic              owner
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RD_LAT - 1);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              last_owner;
    logic              owner_q;
    logic              lat_we;
    logic [CNT_W-1:0]  wait_cnt;

    logic              grant_valid;
    logic              grant_dma;
    logic              gnt_we;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_wdata;
    logic              wait_done;

    // On a tie the requester that did not go last wins; last_owner resets to dma.
    always_comb begin
        grant_valid = cpu_req | dma_req;
        grant_dma   = dma_req & (~cpu_req | ~last_owner);
        gnt_we      = grant_dma ? dma_we    : cpu_we;
        gnt_addr    = grant_dma ? dma_addr  : cpu_addr;
        gnt_wdata   = grant_dma ? dma_wdata : cpu_wdata;
        wait_done   = (state == WAIT) && (wait_cnt == LAST_CNT);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_valid) state_nxt = ISSUE;
            ISSUE:   state_nxt = lat_we ? DONE : WAIT;
            WAIT:    if (wait_done) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory strobes and acks are registered, so each is set on the edge entering the state it belongs to.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            owner_q    <= 1'b0;
            lat_we     <= 1'b0;
            wait_cnt   <= '0;
            cpu_ack    <= 1'b0;
            dma_ack    <= 1'b0;
            cpu_rdata  <= '0;
            dma_rdata  <= '0;
            mem_addr   <= '0;
            mem_data   <= '0;
            mem_wren   <= 1'b0;
            mem_en     <= 1'b0;
        end else begin
            state    <= state_nxt;
            mem_en   <= 1'b0;
            mem_wren <= 1'b0;
            cpu_ack  <= 1'b0;
            dma_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner_q  <= grant_dma;
                        lat_we   <= gnt_we;
                        mem_addr <= gnt_addr;
                        mem_data <= gnt_wdata;
                        mem_en   <= 1'b1;
                        mem_wren <= gnt_we;
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    if (lat_we) begin
                        cpu_ack <= ~owner_q;
                        dma_ack <= owner_q;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    if (wait_done) begin
                        if (owner_q) dma_rdata <= mem_q;
                        else         cpu_rdata <= mem_q;
                        cpu_ack <= ~owner_q;
                        dma_ack <= owner_q;
                    end
                end
                DONE: begin
                    last_owner <= owner_q;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy  = (state != IDLE);
    assign owner = busy & owner_q;

endmodule

// File: tb/tb_md_arbiter.sv
// tb/tb_md_arbiter.sv - directed self-checking bench for md_arbiter (RD_LAT=2 and RD_LAT=1 builds)
module tb_md_arbiter;

    logic        clock;
    logic        reset;

    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [11:0] cpu_addr, dma_addr;
    logic [15:0] cpu_wdata, dma_wdata;
    logic        cpu_ack, dma_ack;
    logic [15:0] cpu_rdata, dma_rdata;
    logic [11:0] mem_addr;
    logic [15:0] mem_data, mem_q;
    logic        mem_wren, mem_en, busy, owner;

    logic        d1_cpu_req, d1_cpu_we, d1_dma_req, d1_dma_we;
    logic [11:0] d1_cpu_addr, d1_dma_addr;
    logic [15:0] d1_cpu_wdata, d1_dma_wdata;
    logic        d1_cpu_ack, d1_dma_ack;
    logic [15:0] d1_cpu_rdata, d1_dma_rdata;
    logic [11:0] d1_mem_addr;
    logic [15:0] d1_mem_data, d1_mem_q;
    logic        d1_mem_wren, d1_mem_en, d1_busy, d1_owner;

    int total = 0;
    int bad   = 0;
    int en_cnt = 0;
    int en_base;
    logic overlap = 1'b0;

    logic [15:0] mem0 [0:4095];
    logic [15:0] mem1 [0:4095];
    logic [15:0] pipe0, q0, q1;

    md_arbiter #(.ADDR_W(12), .DATA_W(16), .RD_LAT(2)) u_dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_en(mem_en),
        .mem_q(mem_q), .busy(busy), .owner(owner)
    );

    md_arbiter #(.ADDR_W(12), .DATA_W(16), .RD_LAT(1)) u_dut1 (
        .clock(clock), .reset(reset),
        .cpu_req(d1_cpu_req), .cpu_we(d1_cpu_we), .cpu_addr(d1_cpu_addr), .cpu_wdata(d1_cpu_wdata),
        .cpu_ack(d1_cpu_ack), .cpu_rdata(d1_cpu_rdata),
        .dma_req(d1_dma_req), .dma_we(d1_dma_we), .dma_addr(d1_dma_addr), .dma_wdata(d1_dma_wdata),
        .dma_ack(d1_dma_ack), .dma_rdata(d1_dma_rdata),
        .mem_addr(d1_mem_addr), .mem_data(d1_mem_data), .mem_wren(d1_mem_wren), .mem_en(d1_mem_en),
        .mem_q(d1_mem_q), .busy(d1_busy), .owner(d1_owner)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory models: data valid RD_LAT cycles after the issue cycle
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_wren) mem0[mem_addr] <= mem_data;
            else          pipe0 <= mem0[mem_addr];
        end
        q0 <= pipe0;
        if (d1_mem_en) begin
            if (d1_mem_wren) mem1[d1_mem_addr] <= d1_mem_data;
            else             q1 <= mem1[d1_mem_addr];
        end
    end
    assign mem_q    = q0;
    assign d1_mem_q = q1;

    always @(negedge clock) begin
        if (cpu_ack && dma_ack) overlap <= 1'b1;
        if (mem_en) en_cnt <= en_cnt + 1;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        {cpu_req, cpu_we, dma_req, dma_we} = '0;
        cpu_addr = '0; dma_addr = '0; cpu_wdata = '0; dma_wdata = '0;
        {d1_cpu_req, d1_cpu_we, d1_dma_req, d1_dma_we} = '0;
        d1_cpu_addr = '0; d1_dma_addr = '0; d1_cpu_wdata = '0; d1_dma_wdata = '0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_acks", {cpu_ack, dma_ack}, 0);
        chk("rst_mem_ctl", {mem_en, mem_wren}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_rdata", {cpu_rdata, dma_rdata}, 0);
        chk("rst_d1_busy", d1_busy, 0);
        reset = 1'b1;
        tick();

        // cpu write 0x012 <- 0x7FFF
        cpu_req = 1; cpu_we = 1; cpu_addr = 12'h012; cpu_wdata = 16'h7FFF;
        chk("wr_c0_busy", busy, 0);
        tick();
        chk("wr_c1_en_wren", {mem_en, mem_wren}, 2'b11);
        chk("wr_c1_addr", mem_addr, 12'h012);
        chk("wr_c1_data", mem_data, 16'h7FFF);
        chk("wr_c1_busy_owner", {busy, owner}, 2'b10);
        chk("wr_c1_ack", cpu_ack, 0);
        tick();
        chk("wr_c2_ack", cpu_ack, 1);
        chk("wr_c2_en", mem_en, 0);
        cpu_req = 0;
        tick();
        chk("wr_c3_ack", cpu_ack, 0);
        chk("wr_c3_busy", busy, 0);

        // cpu read 0x012
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'h012;
        tick();
        chk("rd_c1_en_wren", {mem_en, mem_wren}, 2'b10);
        chk("rd_c1_addr", mem_addr, 12'h012);
        tick();
        chk("rd_c2_en_ack", {mem_en, cpu_ack}, 0);
        tick();
        chk("rd_c3_ack", cpu_ack, 0);
        tick();
        chk("rd_c4_ack", cpu_ack, 1);
        chk("rd_c4_rdata", cpu_rdata, 16'h7FFF);
        chk("rd_c4_dma_rdata", dma_rdata, 0);
        cpu_req = 0;
        tick();
        chk("rd_c5_ack", cpu_ack, 0);
        chk("rd_c5_hold", cpu_rdata, 16'h7FFF);

        // dma write 0x0A0 <- 0x1234
        dma_req = 1; dma_we = 1; dma_addr = 12'h0A0; dma_wdata = 16'h1234;
        tick();
        chk("dwr_c1_owner", {busy, owner}, 2'b11);
        chk("dwr_c1_addr", mem_addr, 12'h0A0);
        tick();
        chk("dwr_c2_acks", {cpu_ack, dma_ack}, 2'b01);
        dma_req = 0;
        tick();

        // dma read 0x012
        dma_req = 1; dma_we = 0; dma_addr = 12'h012;
        tick(); tick(); tick(); tick();
        chk("drd_c4_ack", dma_ack, 1);
        chk("drd_c4_rdata", dma_rdata, 16'h7FFF);
        dma_req = 0;
        tick();

        // cpu read 0x0A0; inputs change and req drops during WAIT
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'h0A0;
        tick();
        chk("chg_c1_addr", mem_addr, 12'h0A0);
        tick();
        cpu_addr = 12'hFFF; cpu_we = 1; cpu_wdata = 16'h0000; cpu_req = 0;
        tick();
        chk("chg_c3_wren", mem_wren, 0);
        tick();
        chk("chg_c4_ack", {cpu_ack, dma_ack}, 2'b10);
        chk("chg_c4_rdata", cpu_rdata, 16'h1234);
        chk("chg_c4_dma_rdata", dma_rdata, 16'h7FFF);
        tick();
        chk("chg_idle", busy, 0);

        // reset in the middle of a cpu read
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'h012;
        tick(); tick();
        chk("mid_in_wait", busy, 1);
        reset = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_en", mem_en, 0);
        chk("mid_rdata", cpu_rdata, 0);
        cpu_req = 0;
        tick(); tick();
        chk("mid_no_ack", {cpu_ack, mem_en, mem_wren}, 0);
        reset = 1'b1;
        tick(); tick();
        chk("mid_after_ack", {cpu_ack, busy}, 0);

        // simultaneous first requests: cpu wins, dma follows
        en_base = en_cnt;
        cpu_req = 1; cpu_we = 1; cpu_addr = 12'h100; cpu_wdata = 16'h0001;
        dma_req = 1; dma_we = 1; dma_addr = 12'h101; dma_wdata = 16'h0002;
        tick();
        chk("sim_c1_owner", {busy, owner}, 2'b10);
        chk("sim_c1_addr", mem_addr, 12'h100);
        tick();
        chk("sim_c2_acks", {cpu_ack, dma_ack}, 2'b10);
        cpu_req = 0;
        tick();
        chk("sim_c3_idle", busy, 0);
        tick();
        chk("sim_c4_owner", {busy, owner}, 2'b11);
        chk("sim_c4_addr", mem_addr, 12'h101);
        tick();
        chk("sim_c5_acks", {cpu_ack, dma_ack}, 2'b01);
        dma_req = 0;
        tick();

        // continuous contention: six alternating grants
        cpu_req = 1; cpu_addr = 12'h200; cpu_wdata = 16'hAAAA;
        dma_req = 1; dma_addr = 12'h300; dma_wdata = 16'h5555;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("alt%0d_owner", k), owner, k % 2);
            chk($sformatf("alt%0d_addr", k), mem_addr, (k % 2 == 0) ? 12'h200 : 12'h300);
            tick();
            chk($sformatf("alt%0d_acks", k), {cpu_ack, dma_ack}, (k % 2 == 0) ? 2'b10 : 2'b01);
            if (k == 5) begin
                cpu_req = 0;
                dma_req = 0;
            end
            tick();
            chk($sformatf("alt%0d_idle", k), busy, 0);
        end
        tick();
        chk("alt_en_pulses", en_cnt - en_base, 8);
        chk("ack_overlap", overlap, 0);

        // RD_LAT=1 build: dma write then read of 0x800
        d1_dma_req = 1; d1_dma_we = 1; d1_dma_addr = 12'h800; d1_dma_wdata = 16'h8001;
        tick(); tick();
        chk("l1_wr_ack", d1_dma_ack, 1);
        d1_dma_req = 0;
        tick();
        d1_dma_req = 1; d1_dma_we = 0;
        tick();
        chk("l1_c1_en", {d1_mem_en, d1_mem_wren}, 2'b10);
        tick();
        chk("l1_c2_ack", d1_dma_ack, 0);
        tick();
        chk("l1_c3_ack", d1_dma_ack, 1);
        chk("l1_c3_rdata", d1_dma_rdata, 16'h8001);
        chk("l1_c3_cpu_rdata", d1_cpu_rdata, 0);
        d1_dma_req = 0;
        tick();
        chk("l1_idle", {d1_busy, d1_dma_ack}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
